keypad_scanner: RTL and testbench

Scans the calculator's 4x4 matrix keypad and turns key presses into one-cycle event strobes with a 4-bit key code. It is the transmit side of the key-event interface: it produces `numero_en`, `operando_en`, `igual_en` and `borrar_en` for the number-entry and operation FSMs. It drives the keypad columns, synchronizes and debounces the rows, and reports exactly one event per physical press.

---
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Drives one active-low column at a
//                time, synchronizes and debounces the rows, and reports each
//                physical press as a single-cycle event strobe plus key code.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,  // clock cycles per column slot (>= 4)
  parameter int DEBOUNCE_CNT = 3   // matching samples to accept press/release (>= 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       numero_en,
  output logic       operando_en,
  output logic       borrar_en,
  output logic       igual_en
);

  localparam int C_DIV_W = $clog2(SCAN_DIV);
  localparam int C_CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(SCAN_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_EMIT         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_row_s1;
  logic [3:0]           r_row_s2;
  logic [C_DIV_W-1:0]   r_div;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]           r_col;
  logic [1:0]           w_col_nxt;
  logic [3:0]           r_cand_row;
  logic [1:0]           r_cand_idx;
  logic [3:0]           r_key_code;
  logic                 w_sample;
  logic                 w_single;
  logic [1:0]           w_row_idx;
  logic                 w_cand_ld;
  logic                 w_emit;
  logic [3:0]           w_code;

  // Sample point: the last cycle of each column slot, so the two-flop
  // synchronizer lag after a column change has already settled.
  assign w_sample = (r_div == C_DIV_LAST);

  // Bring the asynchronous rows into the clock domain (idle value is all high)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
    end
  end

  // Free-running slot divider, independent of the FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_sample) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + C_DIV_W'(1);
    end
  end

  // Classify the synchronized rows: exactly one low bit is a usable key
  always_comb begin
    w_single  = 1'b1;
    w_row_idx = 2'd0;
    case (r_row_s2)
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_single  = 1'b0;
    endcase
  end

  // Map the candidate (row, column) to the calculator key code
  always_comb begin
    w_code = 4'h0;
    case ({r_cand_idx, r_col})
      4'b00_00: w_code = 4'h1;
      4'b00_01: w_code = 4'h2;
      4'b00_10: w_code = 4'h3;
      4'b00_11: w_code = 4'hA;
      4'b01_00: w_code = 4'h4;
      4'b01_01: w_code = 4'h5;
      4'b01_10: w_code = 4'h6;
      4'b01_11: w_code = 4'hB;
      4'b10_00: w_code = 4'h7;
      4'b10_01: w_code = 4'h8;
      4'b10_10: w_code = 4'h9;
      4'b10_11: w_code = 4'hC;
      4'b11_00: w_code = 4'hE;
      4'b11_01: w_code = 4'h0;
      4'b11_10: w_code = 4'hF;
      4'b11_11: w_code = 4'hD;
      default:  w_code = 4'h0;
    endcase
  end

  // Next-state logic: column stepping, debounce/release counting, emit trigger
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_cand_ld   = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_sample) begin
          if (w_single) begin
            w_cand_ld   = 1'b1;
            w_state_nxt = ST_DEBOUNCE;
            w_cnt_nxt   = '0;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_sample) begin
          if (r_row_s2 == r_cand_row) begin
            if (r_cnt == C_CNT_LAST) begin
              w_state_nxt = ST_EMIT;
              w_cnt_nxt   = '0;
              w_emit      = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + C_CNT_W'(1);
            end
          end else begin
            w_state_nxt = ST_SCAN;
            w_cnt_nxt   = '0;
            w_col_nxt   = r_col + 2'd1;
          end
        end
      end
      ST_EMIT: begin
        w_state_nxt = ST_WAIT_RELEASE;
        w_cnt_nxt   = '0;
      end
      ST_WAIT_RELEASE: begin
        if (w_sample) begin
          if (&r_row_s2) begin
            if (r_cnt == C_CNT_LAST) begin
              w_state_nxt = ST_SCAN;
              w_cnt_nxt   = '0;
              w_col_nxt   = r_col + 2'd1;
            end else begin
              w_cnt_nxt = r_cnt + C_CNT_W'(1);
            end
          end else begin
            // Any low row during release restarts the all-high run
            w_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters, column, candidate and key code registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_SCAN;
      r_cnt      <= '0;
      r_col      <= 2'd0;
      r_cand_row <= 4'hF;
      r_cand_idx <= 2'd0;
      r_key_code <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      if (w_cand_ld) begin
        r_cand_row <= r_row_s2;
        r_cand_idx <= w_row_idx;
      end
      // Loaded on entry to EMIT so the code is valid alongside the strobes
      if (w_emit) begin
        r_key_code <= w_code;
      end
    end
  end

  assign col_n       = ~(4'b0001 << r_col);
  assign key_code    = r_key_code;
  assign key_valid   = (r_state == ST_EMIT);
  assign numero_en   = key_valid && (r_key_code <= 4'h9);
  assign operando_en = key_valid && (r_key_code >= 4'hA) && (r_key_code <= 4'hD);
  assign borrar_en   = key_valid && (r_key_code == 4'hE);
  assign igual_en    = key_valid && (r_key_code == 4'hF);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner. A keypad model turns
//                pressed keys into row levels; expected events go into a
//                scoreboard queue that a monitor thread consumes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       numero_en;
  logic       operando_en;
  logic       borrar_en;
  logic       igual_en;

  // Pressed keys, index = row*4 + column
  logic [15:0] pressed = '0;
  logic [3:0]  keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct {
    logic [3:0] code;
    int         at;    // required cycle, or -1 when only order matters
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         t0    = 0;
  logic       rst_q = 1'b1;
  logic [3:0] last_code = 4'h0;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .numero_en  (numero_en),
    .operando_en(operando_en),
    .borrar_en  (borrar_en),
    .igual_en   (igual_en)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a pressed key sits on a driven column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc - t0);
    end
  endtask

  // {key_valid, numero_en, operando_en, borrar_en, igual_en}
  function automatic logic [4:0] exp_strobes(input logic [3:0] code);
    if (code <= 4'h9)       return 5'b11000;
    else if (code <= 4'hD)  return 5'b10100;
    else if (code == 4'hE)  return 5'b10010;
    else                    return 5'b10001;
  endfunction

  function automatic logic [3:0] exp_col(input int k);
    return 4'hF ^ (4'b0001 << ((k / SCAN_DIV) % 4));
  endfunction

  task automatic monitor_step();
    exp_t e;
    if (rst_q) last_code = 4'h0;
    chk("col_onehot", $countones(~col_n), 1);
    if (key_valid || numero_en || operando_en || borrar_en || igual_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'({key_valid, numero_en, operando_en, borrar_en, igual_en}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_code", int'(key_code), int'(e.code));
        chk("event_strobes", int'({key_valid, numero_en, operando_en, borrar_en, igual_en}),
            int'(exp_strobes(e.code)));
        if (e.at >= 0) chk("event_cycle", cyc, e.at);
        last_code = e.code;
      end
    end else begin
      chk("key_code_hold", int'(key_code), int'(last_code));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    chk("missed_event", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic push(input int idx, input int at);
    exp_t e;
    e.code = keymap[idx];
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Stimulus and monitor run as threads of one process
  initial begin
    int s1;
    int rel;
    int seq[3] = '{14, 12, 7};
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset values and idle column rotation
    apply_reset();
    chk("rst_col_n", int'(col_n), 4'b1110);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_strobes", int'({key_valid, numero_en, operando_en, borrar_en, igual_en}), 0);
    for (int k = 0; k < 20; k++) begin
      chk("scan_col_n", int'(col_n), int'(exp_col(k)));
      @(negedge clk);
    end

    // '5' held through reset: detect at cycle 7, strobe at 7 + 3*4 + 1
    pressed[5] = 1'b1;
    apply_reset();
    push(5, t0 + 20);
    wait_until(t0 + 25);  chk("hold5_col_n", int'(col_n), 4'b1101);
    wait_until(t0 + 150); chk("hold5_col_n", int'(col_n), 4'b1101);
    wait_until(t0 + 299); chk("hold5_col_n", int'(col_n), 4'b1101);
    chk("missed_event", exp_q.size(), 0);
    pressed[5] = 1'b0;
    rel = cyc;
    s1 = rel + 2;
    while (((s1 - t0) % SCAN_DIV) != SCAN_DIV - 1) s1++;
    wait_until(s1 + 2*SCAN_DIV); chk("rel5_held", int'(col_n), 4'b1101);
    @(negedge clk);              chk("rel5_advance", int'(col_n), 4'b1011);
    tick(20);

    // '8' bouncing every 3 cycles, then stable
    push(9, -1);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pressed[9] = ~pressed[9];
      @(negedge clk);
    end
    pressed[9] = 1'b1;
    wait_drain(80);
    tick(20);
    pressed[9] = 1'b0;
    tick(40);

    // '#', '*', 'B' in turn
    for (int i = 0; i < 3; i++) begin
      push(seq[i], -1);
      pressed[seq[i]] = 1'b1;
      wait_drain(60);
      tick(20);
      pressed[seq[i]] = 1'b0;
      tick(40);
    end

    // Rows 0 and 1 low together in column 2: no key
    pressed[2] = 1'b1;
    pressed[6] = 1'b1;
    tick(80);
    pressed = '0;
    tick(40);

    // '0' pressed while '5' waits for release: ignored
    push(5, -1);
    pressed[5] = 1'b1;
    wait_drain(60);
    pressed[13] = 1'b1;
    tick(30);
    pressed[5] = 1'b0;
    tick(40);
    pressed[13] = 1'b0;
    tick(40);

    // '3' with a two-sample release glitch: one event only
    push(2, -1);
    pressed[2] = 1'b1;
    wait_drain(60);
    tick(10);
    pressed[2] = 1'b0;
    tick(8);
    pressed[2] = 1'b1;
    tick(40);
    pressed[2] = 1'b0;
    tick(40);

    // Reset during DEBOUNCE, then the still-held key is reported once
    pressed[5] = 1'b1;
    apply_reset();
    wait_until(t0 + 10);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_col_n", int'(col_n), 4'b1110);
    chk("mid_rst_key_code", int'(key_code), 0);
    chk("mid_rst_strobes", int'({key_valid, numero_en, operando_en, borrar_en, igual_en}), 0);
    reset = 1'b0;
    t0 = cyc;
    push(5, t0 + 20);
    wait_drain(40);
    pressed[5] = 1'b0;
    tick(40);

    // Randomized presses: single keys and same-column double presses
    for (int it = 0; it < 24; it++) begin
      int mode;
      int k;
      int c;
      int r1;
      int r2;
      mode = int'($urandom_range(0, 3));
      if (mode < 3) begin
        k = int'($urandom_range(0, 15));
        push(k, -1);
        pressed[k] = 1'b1;
        tick(int'($urandom_range(60, 120)));
        chk("missed_event", exp_q.size(), 0);
      end else begin
        c  = int'($urandom_range(0, 3));
        r1 = int'($urandom_range(0, 3));
        r2 = (r1 + int'($urandom_range(1, 3))) % 4;
        pressed[r1*4+c] = 1'b1;
        pressed[r2*4+c] = 1'b1;
        tick(int'($urandom_range(60, 120)));
      end
      pressed = '0;
      tick(int'($urandom_range(40, 80)));
    end
    wait_drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
